// File: rtl/mux_pkg.sv
// Shared types and constants for the mux select sequencer.
// A select index addresses one of NCH mux inputs.
package mux_pkg;

  localparam int NCH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin search for the next enabled channel after the current one.
// With cur = NCH-1 the result is the lowest enabled channel.
module rr_next_ch
  import mux_pkg::*;
(
  input  logic [NCH-1:0] ch_mask,
  input  sel_t           cur,
  output sel_t           nxt,
  output logic           wrapped
);

  sel_t idx;
  logic found;

  // The last probe (offset NCH) lands on cur itself, so a sole enabled
  // channel reloads onto itself and reports a wrap.
  always_comb begin
    nxt     = cur;
    found   = 1'b0;
    idx     = cur;
    for (int i = 1; i <= NCH; i++) begin
      idx = cur + sel_t'(i);
      if (!found && ch_mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrapped = found && (nxt <= cur);
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Registered select generator for the 4-to-1 mux: steps round-robin through
// enabled channels, holding each for a programmable dwell.
module mux_sel_sequencer
  import mux_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NCH-1:0]     ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  output logic               sel_vld,
  output logic               switch,
  output logic               wrap
);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] reload;
  logic               active;
  sel_t               cur;
  sel_t               nxt;
  logic               wrapped;

  assign active = en && (ch_mask != '0);
  assign reload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // From IDLE the search starts above the top channel, yielding the lowest set bit.
  assign cur = (state == IDLE) ? sel_t'(NCH - 1) : sel;

  rr_next_ch u_next (
    .ch_mask (ch_mask),
    .cur     (cur),
    .nxt     (nxt),
    .wrapped (wrapped)
  );

  // A masked-off current channel forces an advance even mid-dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      sel_vld <= 1'b0;
      switch  <= 1'b0;
      wrap    <= 1'b0;
      cnt     <= '0;
    end else begin
      switch <= 1'b0;
      wrap   <= 1'b0;
      case (state)
        IDLE: begin
          if (active) begin
            state   <= RUN;
            sel     <= nxt;
            cnt     <= reload;
            sel_vld <= 1'b1;
            switch  <= 1'b1;
          end else begin
            sel_vld <= 1'b0;
          end
        end
        RUN: begin
          if (!active) begin
            state   <= IDLE;
            sel_vld <= 1'b0;
          end else if ((cnt != '0) && ch_mask[sel]) begin
            cnt <= cnt - DWELL_W'(1);
          end else begin
            sel    <= nxt;
            cnt    <= reload;
            switch <= (nxt != sel);
            wrap   <= wrapped;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer: stimulus queues hand-derived
// expected outputs, a monitor pops and compares one entry per clock.
module tb_mux_sel_sequencer;
  import mux_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [3:0]    ch_mask = 4'h0;
  logic [DW-1:0] dwell = '0;
  logic [1:0]    sel;
  logic          sel_vld;
  logic          switch;
  logic          wrap;

  logic [4:0] expq[$];
  string      nameq[$];
  int         vectors = 0;
  int         miscompares = 0;

  mux_sel_sequencer #(.DWELL_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ch_mask (ch_mask),
    .dwell   (dwell),
    .sel     (sel),
    .sel_vld (sel_vld),
    .switch  (switch),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] pk(input logic v, input logic [1:0] s,
                                    input logic sw, input logic wr);
    return {v, s, sw, wr};
  endfunction

  // Inputs change on the falling edge; the entry describes the outputs
  // expected after the following rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] m,
                               input logic [DW-1:0] d, input logic [4:0] exp,
                               input string nm);
    @(negedge clk);
    rst     = r;
    en      = e;
    ch_mask = m;
    dwell   = d;
    expq.push_back(exp);
    nameq.push_back(nm);
  endtask

  task automatic checkOutput(input logic [4:0] exp, input string nm);
    logic [4:0] act;
    act = {sel_vld, sel, switch, wrap};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got vld=%b sel=%0d sw=%b wr=%b, want vld=%b sel=%0d sw=%b wr=%b",
               nm, $time, act[4], act[3:2], act[1], act[0],
               exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  initial begin : monitor
    logic [4:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e  = expq.pop_front();
        nm = nameq.pop_front();
        checkOutput(e, nm);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int   ch;
    int   k;
    logic sw;
    logic wr;

    // Reset and IDLE behaviour
    applyStimulus(1'b1, 1'b0, 4'h0, 8'd0, pk(1'b0, 2'd0, 1'b0, 1'b0), "reset0");
    applyStimulus(1'b1, 1'b1, 4'hF, 8'd5, pk(1'b0, 2'd0, 1'b0, 1'b0), "reset_over_en");
    applyStimulus(1'b0, 1'b0, 4'hF, 8'd5, pk(1'b0, 2'd0, 1'b0, 1'b0), "idle_en0");
    applyStimulus(1'b0, 1'b1, 4'h0, 8'd5, pk(1'b0, 2'd0, 1'b0, 1'b0), "idle_mask0");

    // All four channels, dwell 5: 0,1,2,3,0 each for 5 cycles
    for (int n = 0; n < 25; n++) begin
      ch = (n / 5) % 4;
      k  = n % 5;
      sw = (k == 0);
      wr = (k == 0) && (n > 0) && (ch == 0);
      applyStimulus(1'b0, 1'b1, 4'hF, 8'd5, pk(1'b1, 2'(ch), sw, wr), "rr4_d5");
    end

    // One-cycle reset mid-run, then channels 1 and 3 with dwell 3
    applyStimulus(1'b1, 1'b1, 4'b1010, 8'd3, pk(1'b0, 2'd0, 1'b0, 1'b0), "rst_midrun");
    for (int n = 0; n < 12; n++) begin
      ch = (((n / 3) % 2) == 1) ? 3 : 1;
      k  = n % 3;
      sw = (k == 0);
      wr = (k == 0) && (n > 0) && (ch == 1);
      applyStimulus(1'b0, 1'b1, 4'b1010, 8'd3, pk(1'b1, 2'(ch), sw, wr), "rr13_d3");
    end

    // Sole channel 2 with dwell 0: wrap every cycle, switch only at start
    applyStimulus(1'b1, 1'b0, 4'b0100, 8'd0, pk(1'b0, 2'd0, 1'b0, 1'b0), "rst2");
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1'b0, 1'b1, 4'b0100, 8'd0,
                    pk(1'b1, 2'd2, (n == 0), (n > 0)), "sole_d0");
    end

    // Dwell expiring in the same cycle the current channel is masked off
    applyStimulus(1'b1, 1'b0, 4'b0011, 8'd2, pk(1'b0, 2'd0, 1'b0, 1'b0), "rst3");
    applyStimulus(1'b0, 1'b1, 4'b0011, 8'd2, pk(1'b1, 2'd0, 1'b1, 1'b0), "sim_load");
    applyStimulus(1'b0, 1'b1, 4'b0011, 8'd2, pk(1'b1, 2'd0, 1'b0, 1'b0), "sim_hold");
    applyStimulus(1'b0, 1'b1, 4'b0010, 8'd2, pk(1'b1, 2'd1, 1'b1, 1'b0), "sim_adv");
    applyStimulus(1'b0, 1'b1, 4'b0010, 8'd2, pk(1'b1, 2'd1, 1'b0, 1'b0), "sim_hold1");
    applyStimulus(1'b0, 1'b1, 4'b0010, 8'd2, pk(1'b1, 2'd1, 1'b0, 1'b1), "sim_sole_wrap");

    // Mask-off mid-dwell, en drop/restart, mid-dwell dwell change, mask=0
    applyStimulus(1'b1, 1'b0, 4'hF, 8'd7, pk(1'b0, 2'd0, 1'b0, 1'b0), "rst4");
    for (int n = 0; n < 10; n++) begin
      ch = (n < 7) ? 0 : 1;
      applyStimulus(1'b0, 1'b1, 4'hF, 8'd7,
                    pk(1'b1, 2'(ch), (n == 0) || (n == 7), 1'b0), "rr4_d7");
    end
    applyStimulus(1'b0, 1'b1, 4'b1101, 8'd7, pk(1'b1, 2'd2, 1'b1, 1'b0), "mask_midwell");
    applyStimulus(1'b0, 1'b1, 4'b1101, 8'd7, pk(1'b1, 2'd2, 1'b0, 1'b0), "mask_hold");
    applyStimulus(1'b0, 1'b0, 4'b1101, 8'd7, pk(1'b0, 2'd2, 1'b0, 1'b0), "en_off");
    applyStimulus(1'b0, 1'b0, 4'b1101, 8'd7, pk(1'b0, 2'd2, 1'b0, 1'b0), "en_off_idle");
    applyStimulus(1'b0, 1'b1, 4'b1101, 8'd7, pk(1'b1, 2'd0, 1'b1, 1'b0), "en_restart");
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1'b0, 1'b1, 4'b1101, 8'd2, pk(1'b1, 2'd0, 1'b0, 1'b0), "dwell_late");
    end
    applyStimulus(1'b0, 1'b1, 4'b1101, 8'd2, pk(1'b1, 2'd2, 1'b1, 1'b0), "d2_to2");
    applyStimulus(1'b0, 1'b1, 4'b1101, 8'd2, pk(1'b1, 2'd2, 1'b0, 1'b0), "d2_hold2");
    applyStimulus(1'b0, 1'b1, 4'b1101, 8'd2, pk(1'b1, 2'd3, 1'b1, 1'b0), "d2_to3");
    applyStimulus(1'b0, 1'b1, 4'b1101, 8'd2, pk(1'b1, 2'd3, 1'b0, 1'b0), "d2_hold3");
    applyStimulus(1'b0, 1'b1, 4'b1101, 8'd2, pk(1'b1, 2'd0, 1'b1, 1'b1), "d2_wrap");
    applyStimulus(1'b0, 1'b1, 4'b0000, 8'd2, pk(1'b0, 2'd0, 1'b0, 1'b0), "mask_zero");
    applyStimulus(1'b0, 1'b1, 4'b0000, 8'd2, pk(1'b0, 2'd0, 1'b0, 1'b0), "mask_zero_idle");
    applyStimulus(1'b0, 1'b1, 4'b0001, 8'd1, pk(1'b1, 2'd0, 1'b1, 1'b0), "sole0_load");
    applyStimulus(1'b0, 1'b1, 4'b0001, 8'd1, pk(1'b1, 2'd0, 1'b0, 1'b1), "sole0_wrap");
    applyStimulus(1'b0, 1'b1, 4'b0001, 8'd1, pk(1'b1, 2'd0, 1'b0, 1'b1), "sole0_wrap2");

    // Let the monitor drain the scoreboard, within a fixed cycle budget
    for (int w = 0; w < 10 && expq.size() > 0; w++) @(negedge clk);
    if (expq.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, want 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Registered select generator that sits directly upstream of the 4-to-1 `mux` and drives its `sel` input. It steps round-robin through the enabled input channels and holds each one for a programmable number of clock cycles. It emits a valid flag, a pulse on every select change, and a pulse at the end of each round, so downstream samplers and assertions can align to channel boundaries.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input and the internal dwell counter.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  run request; level-sensitive.
- `ch_mask`  input  4  bit i = 1 enables channel i (i=0 is `a`, i=3 is `d`).
- `dwell`  input  DWELL_W  cycles to hold each channel; 0 is treated as 1.
- `sel`  output  2  select to `mux`.
- `sel_vld`  output  1  `sel` is a scheduled channel.
- `switch`  output  1  one-cycle pulse in the first cycle a new `sel` value is presented.
- `wrap`  output  1  one-cycle pulse when the schedule passes from the highest to the lowest enabled channel, or reloads a sole enabled channel.

## Operation
- States: IDLE and RUN.
- Reset:
  - state = IDLE.
  - `sel` = 0, `sel_vld` = 0, `switch` = 0, `wrap` = 0, dwell counter `cnt` = 0.
- IDLE:
  - If `en`=1 and `ch_mask`≠0, go to RUN.
  - `sel` = lowest set bit of `ch_mask`.
  - `cnt` = eff_dwell−1, where eff_dwell = max(`dwell`,1).
  - `sel_vld` = 1, `switch` = 1, `wrap` = 0.
  - Otherwise stay in IDLE with `sel_vld` = 0.
- RUN, with `en`=1 and `ch_mask`≠0:
  - If `cnt`>0 and `ch_mask[sel]`=1: `cnt` decrements and `sel` holds.
  - If `cnt`=0, or `ch_mask[sel]`=0 (current channel masked mid-dwell), advance:
    - `sel` = next set bit of `ch_mask` searching sel+1, sel+2, … modulo 4.
    - `cnt` reloads to eff_dwell−1.
    - `switch` = 1 only if the new `sel` differs from the old one.
    - `wrap` = 1 if the new index ≤ the old index.
- RUN with `en`=0 or `ch_mask`=0:
  - Go to IDLE next edge.
  - `sel_vld` = 0, `sel` holds its last value, `switch`/`wrap` = 0.
- Single enabled channel: `sel` stays constant, `switch` = 0, `wrap` pulses every eff_dwell cycles.
- Sampling of `dwell` and `ch_mask`:
  - `dwell` is sampled only at a load, so a change mid-dwell affects the next channel only.
  - `ch_mask` is sampled every cycle.
- Arithmetic: the channel index wraps modulo 4. `cnt` never underflows because reloads occur at 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `en` rising in IDLE produces `sel_vld`=1 on the next edge, so latency is 1 cycle.
- Each channel holds for exactly eff_dwell cycles.
- Full round period = popcount(`ch_mask`) × eff_dwell cycles.
- `switch` and `wrap` are high for exactly one cycle. They may be asserted in the same cycle.
- `en` deasserting produces `sel_vld`=0 one edge later.
- `rst` overrides everything on the same edge, including mid-dwell.
- Simultaneous `cnt`=0 and current channel masked off: a single advance, the same as either event alone.

## Structure
- Package `mux_pkg`:
  - `sel_t` (logic [1:0]).
  - constant `NCH` = 4.
  - `state_t` enum {IDLE, RUN}.
- Sub-module `rr_next_ch`: combinational. Inputs are `ch_mask` and current `sel`; outputs are the next index and the `wrapped` flag. It is reused by the IDLE load, with current = 3 to give the lowest set bit.
- Top level holds the FSM, `cnt`, and the output registers.

## Test plan
- `ch_mask`=4'b1111, `dwell`=5, `en`=1 after reset → `sel` = 0,1,2,3,0 each held 5 cycles; `switch` every 5 cycles; `wrap` when 3→0.
- `ch_mask`=4'b1010, `dwell`=3 → `sel` alternates 1,3 every 3 cycles; `wrap` on 3→1 only.
- `ch_mask`=4'b0100, `dwell`=0 → `sel`=2 constant, `switch` once at start, `wrap` every cycle.
- Running on `sel`=1 with `cnt`=4, clear `ch_mask[1]` → next edge `sel`=2 with a fresh dwell.
- Deassert `en` mid-dwell on `sel`=2 → `sel_vld`=0 next edge, `sel` stays 2. Reassert → restart at the lowest enabled channel.
- Assert `rst` for 1 cycle mid-RUN → all outputs 0 next edge, then IDLE.
